// File: rtl/dmem_pkg.sv
// Shared encodings and lane helpers for the data-memory load/store unit.
package dmem_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_RESP
    } state_t;

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SZ_B:    return 1'b0;
            SZ_H:    return off[0];
            SZ_W:    return off != 2'b00;
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SZ_B:    return 4'b0001 << off;
            SZ_H:    return off[1] ? 4'b1100 : 4'b0011;
            SZ_W:    return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] load_ext(input logic [31:0] word, input logic [1:0] size,
                                             input logic [1:0] off, input logic uns);
        logic [31:0] shifted;
        logic [7:0]  b;
        logic [15:0] h;
        shifted = word >> {off, 3'b000};
        b       = shifted[7:0];
        h       = off[1] ? word[31:16] : word[15:0];
        case (size)
            SZ_B:    return uns ? {24'b0, b} : {{24{b[7]}}, b};
            SZ_H:    return uns ? {16'b0, h} : {{16{h[15]}}, h};
            default: return word;
        endcase
    endfunction

endpackage

// File: rtl/dmem_lsu_if.sv
// Request/response handshake between the core memory stage and the LSU.
interface dmem_lsu_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_size, req_unsigned,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_size, req_unsigned,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_bank.sv
// Byte-wide synchronous single-port RAM, read-before-write.
module dmem_bank #(
    parameter int unsigned ENTRIES = 1024
) (
    input  logic                       clk,
    input  logic                       en,
    input  logic                       we,
    input  logic [$clog2(ENTRIES)-1:0] addr,
    input  logic [7:0]                 wdata,
    output logic [7:0]                 rdata
);
    logic [7:0] mem [ENTRIES];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) mem[addr] <= wdata;
            rdata <= mem[addr];
        end
    end
endmodule

// File: rtl/dmem_lsu.sv
// Clocked RV32I data-memory LSU: handshake FSM, wait states, fault check, lane steering.
module dmem_lsu
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_BYTES = 4096,
    parameter int unsigned WAIT_STATES = 0
) (
    input logic        clk,
    input logic        rst_n,
    dmem_lsu_if.slave  bus
);
    localparam int unsigned AW      = $clog2(DEPTH_BYTES);
    localparam int unsigned ENTRIES = DEPTH_BYTES / 4;

    state_t          state;
    logic [3:0]      cnt;
    logic            we_q;
    logic [AW-1:0]   addr_q;
    logic [31:0]     wdata_q;
    logic [1:0]      size_q;
    logic            uns_q;
    logic            fault_q;
    logic            rsp_load_q;
    logic            rsp_err_q;

    logic            accept;
    logic            req_fault;
    logic            bank_en;
    logic [3:0]      be;
    logic [31:0]     wlanes;
    logic [7:0]      lane_q [4];

    assign accept    = bus.req_valid && bus.req_ready;
    assign req_fault = misaligned(bus.req_size, bus.req_addr[1:0])
                       || (bus.req_addr >= 32'(DEPTH_BYTES));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            size_q     <= SZ_B;
            uns_q      <= 1'b0;
            fault_q    <= 1'b0;
            rsp_load_q <= 1'b0;
            rsp_err_q  <= 1'b0;
        end else if (accept) begin
            state   <= ST_ACCESS;
            cnt     <= 4'(WAIT_STATES);
            we_q    <= bus.req_we;
            addr_q  <= bus.req_addr[AW-1:0];
            wdata_q <= bus.req_wdata;
            size_q  <= bus.req_size;
            uns_q   <= bus.req_unsigned;
            fault_q <= req_fault;
        end else begin
            case (state)
                ST_ACCESS: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        rsp_load_q <= !we_q && !fault_q;
                        rsp_err_q  <= fault_q;
                        state      <= ST_RESP;
                    end
                end
                ST_RESP: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.req_ready = (state != ST_ACCESS);
    assign bus.rsp_valid = (state == ST_RESP);
    assign bus.rsp_err   = rsp_err_q;

    // The bank output registers capture the array read on the access edge, so they
    // serve as the registered load data; extraction only steers and extends it.
    assign bus.rsp_rdata = rsp_load_q
                           ? load_ext({lane_q[3], lane_q[2], lane_q[1], lane_q[0]},
                                      size_q, addr_q[1:0], uns_q)
                           : '0;

    assign bank_en = rst_n && (state == ST_ACCESS) && (cnt == '0) && !fault_q;
    assign be      = byte_en(size_q, addr_q[1:0]);

    always_comb begin
        wlanes = wdata_q;
        case (size_q)
            SZ_B:    wlanes = {4{wdata_q[7:0]}};
            SZ_H:    wlanes = {2{wdata_q[15:0]}};
            default: wlanes = wdata_q;
        endcase
    end

    for (genvar g = 0; g < 4; g++) begin : g_bank
        dmem_bank #(
            .ENTRIES(ENTRIES)
        ) u_bank (
            .clk   (clk),
            .en    (bank_en),
            .we    (we_q && be[g]),
            .addr  (addr_q[AW-1:2]),
            .wdata (wlanes[8*g +: 8]),
            .rdata (lane_q[g])
        );
    end
endmodule

// File: tb/tb_dmem_lsu.sv
// Randomized and directed checks of dmem_lsu against a byte-array reference model.
module tb_dmem_lsu;
    localparam int unsigned DEPTH = 256;
    localparam int unsigned WS    = 3;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    dmem_lsu_if b3 ();
    dmem_lsu_if b0 ();

    dmem_lsu #(.DEPTH_BYTES(DEPTH), .WAIT_STATES(WS)) u_dut3 (.clk(clk), .rst_n(rst_n), .bus(b3));
    dmem_lsu #(.DEPTH_BYTES(DEPTH), .WAIT_STATES(0))  u_dut0 (.clk(clk), .rst_n(rst_n), .bus(b0));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] mem [2][DEPTH];

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } rsp_t;
    rsp_t exp_q [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Behavioural memory: bytes laid out little-endian, faults from the access rules.
    task automatic model(input int s, input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [1:0] size, input logic uns,
                         output logic [31:0] rd, output logic err);
        int n;
        n   = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        err = (size == 2'd3) || (addr % n != 0) || (addr >= DEPTH);
        rd  = '0;
        if (!err) begin
            if (we) begin
                for (int i = 0; i < n; i++) mem[s][addr + i] = wdata[8*i +: 8];
            end else begin
                for (int i = 0; i < n; i++) rd |= 32'(mem[s][addr + i]) << (8 * i);
                if (!uns && n < 4 && rd[8*n-1]) rd |= ~((32'd1 << (8 * n)) - 32'd1);
            end
        end
    endtask

    task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [1:0] size, input logic uns,
                          output logic [31:0] rdata, output logic err, output int lat);
        @(negedge clk);
        b3.req_valid = 1'b1; b3.req_we = we; b3.req_addr = addr;
        b3.req_wdata = wdata; b3.req_size = size; b3.req_unsigned = uns;
        chk("ready_idle", 32'(b3.req_ready), 32'd1);
        @(posedge clk); #1;
        b3.req_valid = 1'b0;
        lat = 0;
        while (!b3.rsp_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!b3.rsp_valid) lat = -1;
        rdata = b3.rsp_rdata;
        err   = b3.rsp_err;
        @(posedge clk); #1;
        chk("rsp_pulse", 32'(b3.rsp_valid), 32'd0);
    endtask

    task automatic op(input string tag, input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [1:0] size, input logic uns, output logic [31:0] rd);
        logic [31:0] erd;
        logic        eerr;
        logic        err;
        int          lat;
        do_req(we, addr, wdata, size, uns, rd, err, lat);
        model(0, we, addr, wdata, size, uns, erd, eerr);
        chk({tag, "_rdata"}, rd, erd);
        chk({tag, "_err"}, 32'(err), 32'(eerr));
        chk({tag, "_lat"}, 32'(lat), 32'(WS + 1));
    endtask

    task automatic rand_op(output logic we, output logic [31:0] addr, output logic [31:0] wdata,
                           output logic [1:0] size, output logic uns);
        int r;
        int n;
        r     = int'($urandom_range(0, 9));
        size  = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
        n     = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        we    = 1'($urandom_range(0, 1));
        uns   = 1'($urandom_range(0, 1));
        wdata = $urandom;
        if ($urandom_range(0, 9) == 0) addr = $urandom_range(0, DEPTH + 8);
        else addr = $urandom_range(0, DEPTH - 1) & ~(n - 1);
    endtask

    logic [31:0] rd;
    logic        rwe;
    logic [31:0] raddr;
    logic [31:0] rwdata;
    logic [1:0]  rsize;
    logic        runs;

    initial begin
        checks = 0; failures = 0;
        b3.req_valid = 1'b0; b3.req_we = 1'b0; b3.req_addr = '0;
        b3.req_wdata = '0; b3.req_size = 2'd0; b3.req_unsigned = 1'b0;
        b0.req_valid = 1'b0; b0.req_we = 1'b0; b0.req_addr = '0;
        b0.req_wdata = '0; b0.req_size = 2'd0; b0.req_unsigned = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 32'(b3.req_ready), 32'd1);
        chk("rst_valid", 32'(b3.rsp_valid), 32'd0);
        chk("rst_rdata", b3.rsp_rdata, 32'd0);
        chk("rst_err", 32'(b3.rsp_err), 32'd0);
        rst_n = 1'b1;

        for (int a = 0; a < int'(DEPTH); a += 4) begin
            @(negedge clk);
            op("init", 1'b1, 32'(a), $urandom, 2'd2, 1'b0, rd);
        end

        op("sw10", 1'b1, 32'h10, 32'h11223344, 2'd2, 1'b0, rd);
        op("lw10", 1'b0, 32'h10, 32'h0, 2'd2, 1'b0, rd);
        chk("lw10_const", rd, 32'h11223344);

        // Store abandoned by reset while the access is still counting down.
        @(negedge clk);
        b3.req_valid = 1'b1; b3.req_we = 1'b1; b3.req_addr = 32'h10;
        b3.req_wdata = 32'h55667788; b3.req_size = 2'd2;
        @(posedge clk); #1;
        b3.req_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #2;
        chk("midrst_ready", 32'(b3.req_ready), 32'd1);
        chk("midrst_valid", 32'(b3.rsp_valid), 32'd0);
        #2;
        rst_n = 1'b1;
        begin
            int seen;
            seen = 0;
            repeat (8) begin
                @(posedge clk); #1;
                if (b3.rsp_valid) seen++;
            end
            chk("midrst_norsp", 32'(seen), 32'd0);
        end
        op("lw10_after", 1'b0, 32'h10, 32'h0, 2'd2, 1'b0, rd);
        chk("lw10_after_const", rd, 32'h11223344);

        op("sb21", 1'b1, 32'h21, 32'h00000080, 2'd0, 1'b0, rd);
        op("lb21", 1'b0, 32'h21, 32'h0, 2'd0, 1'b0, rd);
        chk("lb21_const", rd, 32'hFFFFFF80);
        op("lbu21", 1'b0, 32'h21, 32'h0, 2'd0, 1'b1, rd);
        chk("lbu21_const", rd, 32'h00000080);
        op("lbu20", 1'b0, 32'h20, 32'h0, 2'd0, 1'b1, rd);
        op("lbu22", 1'b0, 32'h22, 32'h0, 2'd0, 1'b1, rd);
        op("lbu23", 1'b0, 32'h23, 32'h0, 2'd0, 1'b1, rd);

        op("sh32", 1'b1, 32'h32, 32'h1234BEEF, 2'd1, 1'b0, rd);
        op("lw30", 1'b0, 32'h30, 32'h0, 2'd2, 1'b0, rd);
        chk("lw30_upper", {16'h0, rd[31:16]}, 32'h0000BEEF);
        op("lh32", 1'b0, 32'h32, 32'h0, 2'd1, 1'b0, rd);
        chk("lh32_const", rd, 32'hFFFFBEEF);
        op("lhu32", 1'b0, 32'h32, 32'h0, 2'd1, 1'b1, rd);
        chk("lhu32_const", rd, 32'h0000BEEF);

        op("f_lw41", 1'b0, 32'h41, 32'h0, 2'd2, 1'b0, rd);
        op("f_sh43", 1'b1, 32'h43, 32'hAAAA5555, 2'd1, 1'b0, rd);
        op("f_sz11", 1'b1, 32'h40, 32'hDEADBEEF, 2'd3, 1'b0, rd);
        op("f_lwdep", 1'b0, 32'(DEPTH), 32'h0, 2'd2, 1'b0, rd);
        op("lw40", 1'b0, 32'h40, 32'h0, 2'd2, 1'b0, rd);

        repeat (80) begin
            rand_op(rwe, raddr, rwdata, rsize, runs);
            op("rand", rwe, raddr, rwdata, rsize, runs, rd);
        end

        // Back-to-back stream on the zero-wait-state instance with req_valid held high.
        begin
            localparam int N = 48;
            logic        s_we   [N];
            logic [31:0] s_addr [N];
            logic [31:0] s_wd   [N];
            logic [1:0]  s_sz   [N];
            int          i;
            int          cyc;
            int          prev_acc;
            logic        prev_v;
            logic        rdy;
            rsp_t        e;
            logic [31:0] erd;
            logic        eerr;
            for (int k = 0; k < N; k++) begin
                s_sz[k] = 2'd2;
                if (k < 16) begin
                    s_we[k] = 1'b1; s_addr[k] = 32'(4 * k);
                end else begin
                    s_we[k] = 1'($urandom_range(0, 1));
                    s_addr[k] = 32'(4 * $urandom_range(0, 15));
                    if ($urandom_range(0, 7) == 0) s_addr[k] = s_addr[k] + 32'd2;
                end
                s_wd[k] = $urandom;
            end
            i = 0; cyc = 0; prev_acc = -1; prev_v = 1'b0;
            @(negedge clk);
            b0.req_valid = 1'b1; b0.req_we = s_we[0]; b0.req_addr = s_addr[0];
            b0.req_wdata = s_wd[0]; b0.req_size = s_sz[0]; b0.req_unsigned = 1'b0;
            while ((i < N || exp_q.size() > 0) && cyc < 1000) begin
                if (b0.rsp_valid) begin
                    chk("tp_single_pulse", 32'(prev_v), 32'd0);
                    if (exp_q.size() == 0) begin
                        chk("tp_spurious", 32'd1, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("tp_rdata", b0.rsp_rdata, e.rdata);
                        chk("tp_err", 32'(b0.rsp_err), 32'(e.err));
                    end
                end
                prev_v = b0.rsp_valid;
                rdy = b0.req_ready;
                @(posedge clk);
                cyc++;
                if (i < N && rdy) begin
                    model(1, s_we[i], s_addr[i], s_wd[i], s_sz[i], 1'b0, erd, eerr);
                    exp_q.push_back('{rdata: erd, err: eerr});
                    if (prev_acc >= 0) chk("tp_gap", 32'(cyc - prev_acc), 32'd2);
                    prev_acc = cyc;
                    i++;
                end
                @(negedge clk);
                if (i < N) begin
                    b0.req_we = s_we[i]; b0.req_addr = s_addr[i]; b0.req_wdata = s_wd[i];
                end else begin
                    b0.req_valid = 1'b0;
                end
            end
            chk("tp_drain", 32'(exp_q.size()), 32'd0);
            chk("tp_count", 32'(i), 32'(N));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
